// File: rtl/lcd_bus_responder.sv
// Display-side responder for the 4-bit character-LCD bus: rebuilds bytes from nibbles,
// models the DDRAM address counter and busy flag, and answers busy/address reads.
`timescale 1ns/1ps
module lcd_bus_responder #(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] lcd_db_in,
    output logic [3:0] lcd_db_out,
    output logic       lcd_db_oe,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_rs,
    output logic       busy,
    output logic [6:0] addr,
    output logic       mode_4bit,
    output logic       busy_violation
);

    localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        INIT8,
        HI,
        LO
    } state_t;

    function automatic logic [6:0] next_ddram_addr(input logic [6:0] a);
        if (a == 7'h27) begin
            return 7'h40;
        end else if (a == 7'h67) begin
            return 7'h00;
        end else begin
            return a + 7'd1;
        end
    endfunction

    // bus vector layout: {e, rs, rw, db[3:0]}
    logic [6:0]       bus_p0_q, bus_p0_d;
    logic [6:0]       bus_s_q, bus_s_d;
    logic             e_prev_q, e_prev_d;
    logic             cap_rs_q, cap_rs_d;
    logic             cap_rw_q, cap_rw_d;
    logic [3:0]       cap_db_q, cap_db_d;
    logic             commit_q, commit_d;

    state_t           state_q, state_d;
    logic [3:0]       hi_nib_q, hi_nib_d;
    logic             hi_rs_q, hi_rs_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [6:0]       addr_q, addr_d;
    logic             mode_4bit_q, mode_4bit_d;
    logic             viol_q, viol_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_rs_q, byte_rs_d;
    logic             oe_q, oe_d;
    logic [3:0]       db_out_q, db_out_d;

    logic             e_s, rs_s, rw_s;
    logic [3:0]       db_s;
    logic [7:0]       full_byte;
    logic             load_busy;
    logic [CNT_W-1:0] load_val;
    logic [3:0]       rd_nib;

    assign {e_s, rs_s, rw_s, db_s} = bus_s_q;
    assign full_byte = {hi_nib_q, cap_db_q};

    // Stage p0/s: synchronize the bus, hold the fields of the last enabled cycle,
    // and register the falling edge of e as the commit strobe.
    always_comb begin
        bus_p0_d = {lcd_e, lcd_rs, lcd_rw, lcd_db_in};
        bus_s_d  = bus_p0_q;
        e_prev_d = e_s;
        commit_d = e_prev_q & ~e_s;
        cap_rs_d = cap_rs_q;
        cap_rw_d = cap_rw_q;
        cap_db_d = cap_db_q;
        if (e_s) begin
            cap_rs_d = rs_s;
            cap_rw_d = rw_s;
            cap_db_d = db_s;
        end
    end

    // Commit stage: nibble FSM, byte decode and busy counter.
    always_comb begin
        state_d      = state_q;
        hi_nib_d     = hi_nib_q;
        hi_rs_d      = hi_rs_q;
        phase_d      = phase_q;
        addr_d       = addr_q;
        mode_4bit_d  = mode_4bit_q;
        viol_d       = viol_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        byte_rs_d    = byte_rs_q;
        load_busy    = 1'b0;
        load_val     = BUSY_LOAD;

        if (commit_q) begin
            if (cap_rw_q) begin
                if (state_q != INIT8) begin
                    phase_d = ~phase_q;
                end
            end else begin
                phase_d = 1'b0;
                if (busy_q) begin
                    viol_d = 1'b1;
                end
                case (state_q)
                    INIT8: begin
                        if (!cap_rs_q && cap_db_q == 4'h3) begin
                            load_busy = 1'b1;
                        end else if (!cap_rs_q && cap_db_q == 4'h2) begin
                            mode_4bit_d = 1'b1;
                            state_d     = HI;
                            load_busy   = 1'b1;
                        end
                    end
                    HI: begin
                        hi_nib_d = cap_db_q;
                        hi_rs_d  = cap_rs_q;
                        state_d  = LO;
                    end
                    LO: begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = full_byte;
                        byte_rs_d    = hi_rs_q;
                        state_d      = HI;
                        load_busy    = 1'b1;
                        if (hi_rs_q) begin
                            addr_d = next_ddram_addr(addr_q);
                        end else if (full_byte[7:2] == 6'd0 && full_byte[1:0] != 2'd0) begin
                            addr_d   = 7'h00;
                            load_val = CLEAR_LOAD;
                        end else if (full_byte[7]) begin
                            addr_d = full_byte[6:0];
                        end
                    end
                    default: state_d = INIT8;
                endcase
            end
        end

        if (load_busy) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = '0;
        end
        busy_d = (cnt_d != '0);
    end

    // Read-back stage: the bus is driven only while a synchronized read is enabled.
    always_comb begin
        rd_nib = 4'h0;
        if (!rs_s) begin
            if (state_q == INIT8) begin
                rd_nib = {busy_q, 3'b000};
            end else if (phase_q) begin
                rd_nib = addr_q[3:0];
            end else begin
                rd_nib = {busy_q, addr_q[6:4]};
            end
        end
        oe_d     = e_s & rw_s;
        db_out_d = oe_d ? rd_nib : 4'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_p0_q     <= '0;
            bus_s_q      <= '0;
            e_prev_q     <= 1'b0;
            cap_rs_q     <= 1'b0;
            cap_rw_q     <= 1'b0;
            cap_db_q     <= 4'h0;
            commit_q     <= 1'b0;
            state_q      <= INIT8;
            hi_nib_q     <= 4'h0;
            hi_rs_q      <= 1'b0;
            phase_q      <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            addr_q       <= 7'h00;
            mode_4bit_q  <= 1'b0;
            viol_q       <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_rs_q    <= 1'b0;
            oe_q         <= 1'b0;
            db_out_q     <= 4'h0;
        end else begin
            bus_p0_q     <= bus_p0_d;
            bus_s_q      <= bus_s_d;
            e_prev_q     <= e_prev_d;
            cap_rs_q     <= cap_rs_d;
            cap_rw_q     <= cap_rw_d;
            cap_db_q     <= cap_db_d;
            commit_q     <= commit_d;
            state_q      <= state_d;
            hi_nib_q     <= hi_nib_d;
            hi_rs_q      <= hi_rs_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            mode_4bit_q  <= mode_4bit_d;
            viol_q       <= viol_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            byte_rs_q    <= byte_rs_d;
            oe_q         <= oe_d;
            db_out_q     <= db_out_d;
        end
    end

    assign lcd_db_out     = db_out_q;
    assign lcd_db_oe      = oe_q;
    assign byte_valid     = byte_valid_q;
    assign byte_data      = byte_data_q;
    assign byte_rs        = byte_rs_q;
    assign busy           = busy_q;
    assign addr           = addr_q;
    assign mode_4bit      = mode_4bit_q;
    assign busy_violation = viol_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Randomized bench for lcd_bus_responder against a cycle-stamped behavioural model
// of the nibble protocol, address counter, busy timing and read-back.
`timescale 1ns/1ps
module tb_lcd_bus_responder;

    localparam int B = 40;
    localparam int C = 150;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_e = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [3:0] lcd_db_in = 4'h0;
    logic [3:0] lcd_db_out;
    logic       lcd_db_oe;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_rs;
    logic       busy;
    logic [6:0] addr;
    logic       mode_4bit;
    logic       busy_violation;

    lcd_bus_responder #(.BUSY_CYCLES(B), .CLEAR_CYCLES(C)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_db_in(lcd_db_in), .lcd_db_out(lcd_db_out), .lcd_db_oe(lcd_db_oe),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_rs(byte_rs), .busy(busy),
        .addr(addr), .mode_4bit(mode_4bit), .busy_violation(busy_violation)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    // Model: protocol phase 0=init, 1=expect high nibble, 2=expect low nibble.
    int   m_state = 0;
    int   m_addr = 0;
    int   m_busy_end = 0;
    int   m_hi = 0;
    bit   m_hi_rs = 0;
    bit   m_mode = 0;
    bit   m_viol = 0;
    bit   m_phase = 0;

    function automatic bit busy_at(input int c);
        return c < m_busy_end;
    endfunction

    task automatic model_reset();
        m_state = 0; m_addr = 0; m_busy_end = 0; m_hi = 0; m_hi_rs = 0;
        m_mode = 0; m_viol = 0; m_phase = 0;
    endtask

    task automatic write_nibble(input bit rs, input logic [3:0] nib);
        int cc;
        int dur;
        bit exp_valid;
        int exp_byte;
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = 1'b0; lcd_db_in = nib; lcd_e = 1'b1;
        repeat (5) @(posedge clk);
        #1 lcd_e = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (byte_valid !== 1'b0) $display("FAIL early_valid: byte_valid=%b required 0", byte_valid);
        else n_pass++;
        @(posedge clk); #1;
        cc = cyc;
        if (busy_at(cc - 1)) m_viol = 1;
        m_phase = 0;
        exp_valid = 0;
        exp_byte = 0;
        dur = 0;
        if (m_state == 0) begin
            if (!rs && nib == 4'h3) dur = B;
            else if (!rs && nib == 4'h2) begin m_mode = 1; m_state = 1; dur = B; end
        end else if (m_state == 1) begin
            m_hi = int'(nib); m_hi_rs = rs; m_state = 2;
        end else begin
            exp_byte = m_hi * 16 + int'(nib);
            exp_valid = 1; m_state = 1; dur = B;
            if (m_hi_rs) m_addr = (m_addr == 39) ? 64 : (m_addr == 103) ? 0 : (m_addr + 1) % 128;
            else if (exp_byte >= 1 && exp_byte <= 3) begin m_addr = 0; dur = C; end
            else if (exp_byte >= 128) m_addr = exp_byte - 128;
        end
        if (dur > 0) m_busy_end = cc + dur;
        n_checks++;
        if (byte_valid !== exp_valid) $display("FAIL commit_valid: byte_valid=%b required %b", byte_valid, exp_valid);
        else n_pass++;
        if (exp_valid) begin
            n_checks++;
            if (byte_data !== 8'(exp_byte) || byte_rs !== m_hi_rs)
                $display("FAIL byte: data=%h rs=%b required data=%h rs=%b", byte_data, byte_rs, 8'(exp_byte), m_hi_rs);
            else n_pass++;
        end
        n_checks++;
        if (addr !== 7'(m_addr) || busy !== busy_at(cc) || mode_4bit !== m_mode || busy_violation !== m_viol)
            $display("FAIL commit_state: addr=%h busy=%b mode=%b viol=%b required addr=%h busy=%b mode=%b viol=%b",
                     addr, busy, mode_4bit, busy_violation, 7'(m_addr), busy_at(cc), m_mode, m_viol);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (byte_valid !== 1'b0) $display("FAIL valid_width: byte_valid=%b required 0", byte_valid);
        else n_pass++;
    endtask

    task automatic write_byte(input bit rs, input logic [7:0] b);
        write_nibble(rs, b[7:4]);
        write_nibble(rs, b[3:0]);
    endtask

    task automatic lcd_read(input bit rs);
        logic [3:0] exp;
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = 1'b1; lcd_db_in = 4'($urandom); lcd_e = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (rs) exp = 4'h0;
        else if (m_state == 0) exp = {busy_at(cyc - 1), 3'b000};
        else if (m_phase) exp = 4'(m_addr % 16);
        else exp = {busy_at(cyc - 1), 3'(m_addr / 16)};
        n_checks++;
        if (lcd_db_oe !== 1'b1 || lcd_db_out !== exp)
            $display("FAIL read: oe=%b db_out=%h required oe=1 db_out=%h", lcd_db_oe, lcd_db_out, exp);
        else n_pass++;
        lcd_e = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        if (m_state != 0) m_phase = ~m_phase;
        n_checks++;
        if (lcd_db_oe !== 1'b0 || addr !== 7'(m_addr) || byte_valid !== 1'b0)
            $display("FAIL read_end: oe=%b addr=%h valid=%b required oe=0 addr=%h valid=0",
                     lcd_db_oe, addr, byte_valid, 7'(m_addr));
        else n_pass++;
        lcd_rw = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        bit expect_fall;
        expect_fall = busy_at(cyc);
        n = 0;
        while (busy === 1'b1 && n < C + 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL busy_timeout: busy=%b after %0d cycles required 0", busy, n);
        else if (expect_fall && cyc != m_busy_end) $display("FAIL busy_len: fell at cycle %0d required %0d", cyc, m_busy_end);
        else if (!expect_fall && n != 0) $display("FAIL busy_extra: busy for %0d cycles required 0", n);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if ({lcd_db_out, lcd_db_oe, byte_valid, byte_data, byte_rs, busy, addr, mode_4bit, busy_violation} !== 26'd0)
            $display("FAIL reset_values: out=%h oe=%b v=%b d=%h rs=%b busy=%b addr=%h mode=%b viol=%b required all 0",
                     lcd_db_out, lcd_db_oe, byte_valid, byte_data, byte_rs, busy, addr, mode_4bit, busy_violation);
        else n_pass++;
    endtask

    task automatic test_init();
        lcd_read(1'b0);
        write_nibble(1'b0, 4'h3);
        lcd_read(1'b0);
        wait_idle();
        write_nibble(1'b0, 4'h3);
        wait_idle();
        write_nibble(1'b0, 4'h3);
        wait_idle();
        n_checks++;
        if (mode_4bit !== 1'b0) $display("FAIL init_mode_early: mode_4bit=%b required 0", mode_4bit);
        else n_pass++;
        write_nibble(1'b0, 4'h2);
        wait_idle();
        n_checks++;
        if (mode_4bit !== 1'b1 || busy_violation !== 1'b0)
            $display("FAIL init_done: mode_4bit=%b viol=%b required 1 0", mode_4bit, busy_violation);
        else n_pass++;
    endtask

    task automatic test_data_byte();
        write_byte(1'b1, 8'h48);
        n_checks++;
        if (byte_data !== 8'h48 || byte_rs !== 1'b1 || addr !== 7'h01)
            $display("FAIL data_byte: data=%h rs=%b addr=%h required 48 1 01", byte_data, byte_rs, addr);
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_addr_wrap();
        write_byte(1'b0, 8'hA7);
        wait_idle();
        write_byte(1'b1, 8'($urandom));
        n_checks++;
        if (addr !== 7'h40) $display("FAIL wrap_line1: addr=%h required 40", addr);
        else n_pass++;
        wait_idle();
        write_byte(1'b0, 8'hE7);
        wait_idle();
        write_byte(1'b1, 8'($urandom));
        n_checks++;
        if (addr !== 7'h00) $display("FAIL wrap_line2: addr=%h required 00", addr);
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_clear_reads();
        write_byte(1'b0, 8'h45);
        wait_idle();
        write_byte(1'b0, 8'h01);
        lcd_read(1'b0);
        lcd_read(1'b0);
        wait_idle();
        lcd_read(1'b0);
        lcd_read(1'b0);
        write_byte(1'b0, 8'h03);
        wait_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: begin write_byte(1'b1, 8'($urandom)); wait_idle(); end
                1: begin write_byte(1'b0, 8'(8'h80 | 8'($urandom_range(0, 127)))); wait_idle(); end
                2: begin write_byte(1'b0, 8'($urandom_range(4, 127))); wait_idle(); end
                default: lcd_read(1'($urandom));
            endcase
        end
    endtask

    task automatic test_back_to_back();
        write_byte(1'b1, 8'h55);
        write_byte(1'b1, 8'h66);
        n_checks++;
        if (busy_violation !== 1'b1) $display("FAIL violation_set: busy_violation=%b required 1", busy_violation);
        else n_pass++;
        wait_idle();
        write_byte(1'b1, 8'h77);
        wait_idle();
        n_checks++;
        if (busy_violation !== 1'b1) $display("FAIL violation_sticky: busy_violation=%b required 1", busy_violation);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        write_nibble(1'b1, 4'hA);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({lcd_db_out, lcd_db_oe, byte_valid, byte_data, byte_rs, busy, addr, mode_4bit, busy_violation} !== 26'd0)
            $display("FAIL reset_mid: d=%h busy=%b addr=%h mode=%b viol=%b required all 0",
                     byte_data, busy, addr, mode_4bit, busy_violation);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        write_nibble(1'b0, 4'h2);
        n_checks++;
        if (mode_4bit !== 1'b1 || byte_valid !== 1'b0)
            $display("FAIL reset_mid_init: mode_4bit=%b valid=%b required 1 0", mode_4bit, byte_valid);
        else n_pass++;
        wait_idle();
        write_byte(1'b1, 8'h31);
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_init();
        test_data_byte();
        test_addr_wrap();
        test_clear_reads();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
